// File: rtl/ternary_pkg.sv
// Shared types for the balanced-ternary ALU and its writeback stage.
// Trit encoding: 00 = zero, 01 = +1, 10 = -1, 11 = invalid.
package ternary_pkg;

    typedef enum logic [1:0] {
        T_ZERO    = 2'b00,
        T_POS_ONE = 2'b01,
        T_NEG_ONE = 2'b10,
        T_INVALID = 2'b11
    } trit_t;

    localparam int TERNARY_WIDTH      = 8;
    localparam int DEFAULT_REG_ADDR_W = 4;

    typedef struct packed {
        trit_t [TERNARY_WIDTH-1:0]     result;
        trit_t                         carry;
        logic                          zero;
        logic                          neg;
        logic [DEFAULT_REG_ADDR_W-1:0] rd;
        logic                          we;
        logic                          flags_we;
        logic                          invalid;
    } wb_entry_t;

    typedef struct packed {
        logic  z;
        logic  n;
        trit_t c;
    } cond_flags_t;

    function automatic logic t_is_invalid(input trit_t t);
        return (t == T_INVALID);
    endfunction

endpackage

// File: rtl/ternary_wb_fifo2.sv
// Two-entry FIFO of writeback entries. The head is read straight from
// the storage registers, so the output carries no combinational path
// from push/pop. Push while full and pop while empty are ignored.
module ternary_wb_fifo2
    import ternary_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output wb_entry_t head_entry,
    output logic      full,
    output logic      empty
);

    wb_entry_t  mem [2];
    logic       head;
    logic       tail;
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage, pointers and occupancy; reset discards everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            head   <= 1'b0;
            tail   <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[tail] <= push_entry;
                tail      <= ~tail;
            end
            if (do_pop) begin
                head <= ~head;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_entry = mem[head];
    assign full       = (count == 2'd2);
    assign empty      = (count == 2'd0);

endmodule

// File: rtl/ternary_alu_wb_stage.sv
// Writeback stage behind the balanced-ternary ALU: buffers results in a
// 2-entry FIFO, drives the register-file write port, and retires the
// Z/N/C flags and sticky error in program order (at pop time).
// Optional operand-forwarding outputs are enabled by TERNARY_WB_FWD_EN.
module ternary_alu_wb_stage
    import ternary_pkg::*;
#(
    parameter int WIDTH      = TERNARY_WIDTH,
    parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  trit_t [WIDTH-1:0]     in_result,
    input  trit_t                 in_carry,
    input  logic                  in_zero,
    input  logic                  in_neg,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_we,
    input  logic                  in_flags_we,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output trit_t [WIDTH-1:0]     wb_data,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_we,
    output logic                  flag_z,
    output logic                  flag_n,
    output trit_t                 flag_c,
    output logic                  err_sticky,
    input  logic                  err_clr
`ifdef TERNARY_WB_FWD_EN
    ,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output trit_t [WIDTH-1:0]     fwd_data
`endif
);

    // The entry struct is sized by the package, so the parameters must agree.
    if (DEPTH != 2) begin : g_bad_depth
        $error("ternary_alu_wb_stage: only DEPTH=2 is supported");
    end
    if (WIDTH != TERNARY_WIDTH) begin : g_bad_width
        $error("ternary_alu_wb_stage: WIDTH must equal TERNARY_WIDTH");
    end
    if (REG_ADDR_W != DEFAULT_REG_ADDR_W) begin : g_bad_addr
        $error("ternary_alu_wb_stage: REG_ADDR_W must equal DEFAULT_REG_ADDR_W");
    end

    wb_entry_t   push_entry;
    wb_entry_t   head;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        in_invalid;
    cond_flags_t flags_q;
    logic        err_q;

    // Flag an entry invalid if any result trit or the carry is T_INVALID.
    always_comb begin
        in_invalid = t_is_invalid(in_carry);
        for (int k = 0; k < WIDTH; k++) begin
            in_invalid = in_invalid | t_is_invalid(in_result[k]);
        end
    end

    // Pack the ALU outputs into a buffer entry.
    always_comb begin
        push_entry          = '0;
        push_entry.result   = in_result;
        push_entry.carry    = in_carry;
        push_entry.zero     = in_zero;
        push_entry.neg      = in_neg;
        push_entry.rd       = in_rd;
        push_entry.we       = in_we;
        push_entry.flags_we = in_flags_we;
        push_entry.invalid  = in_invalid;
    end

    assign in_ready = ~full;
    assign wb_valid = ~empty;
    assign push     = in_valid && in_ready;
    assign pop      = wb_valid && wb_ready;

    ternary_wb_fifo2 u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head),
        .full       (full),
        .empty      (empty)
    );

    assign wb_data = head.result;
    assign wb_rd   = head.rd;
    assign wb_we   = head.we && !head.invalid;

    // Architectural flags update when a valid flag-writing entry retires.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= '{z: 1'b0, n: 1'b0, c: T_ZERO};
        end else if (pop && head.flags_we && !head.invalid) begin
            flags_q <= '{z: head.zero, n: head.neg, c: head.carry};
        end
    end

    // Sticky error: retiring an invalid entry sets it and beats a clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (pop && head.invalid) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign flag_z     = flags_q.z;
    assign flag_n     = flags_q.n;
    assign flag_c     = flags_q.c;
    assign err_sticky = err_q;

`ifdef TERNARY_WB_FWD_EN
    assign fwd_valid = wb_valid && wb_we;
    assign fwd_rd    = head.rd;
    assign fwd_data  = head.result;
`endif

endmodule

// File: tb/tb_ternary_alu_wb_stage.sv
// Directed self-checking bench for ternary_alu_wb_stage.
// Forwarding checks are included when TERNARY_WB_FWD_EN is defined.
module tb_ternary_alu_wb_stage;
    import ternary_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    trit_t [7:0]       in_result;
    trit_t             in_carry;
    logic              in_zero;
    logic              in_neg;
    logic [3:0]        in_rd;
    logic              in_we;
    logic              in_flags_we;
    logic              wb_valid;
    logic              wb_ready;
    trit_t [7:0]       wb_data;
    logic [3:0]        wb_rd;
    logic              wb_we;
    logic              flag_z;
    logic              flag_n;
    trit_t             flag_c;
    logic              err_sticky;
    logic              err_clr;
`ifdef TERNARY_WB_FWD_EN
    logic              fwd_valid;
    logic [3:0]        fwd_rd;
    trit_t [7:0]       fwd_data;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ternary_alu_wb_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_carry    (in_carry),
        .in_zero     (in_zero),
        .in_neg      (in_neg),
        .in_rd       (in_rd),
        .in_we       (in_we),
        .in_flags_we (in_flags_we),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_data     (wb_data),
        .wb_rd       (wb_rd),
        .wb_we       (wb_we),
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .flag_c      (flag_c),
        .err_sticky  (err_sticky),
        .err_clr     (err_clr)
`ifdef TERNARY_WB_FWD_EN
        ,
        .fwd_valid   (fwd_valid),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Integer to 8-trit balanced ternary, trit 0 least significant.
    function automatic trit_t [7:0] to_bt(input int v);
        trit_t [7:0] t;
        int x;
        int r;
        x = v;
        for (int k = 0; k < 8; k++) begin
            r = ((x % 3) + 3) % 3;
            if (r == 0) begin
                t[k] = T_ZERO;
                x = x / 3;
            end else if (r == 1) begin
                t[k] = T_POS_ONE;
                x = (x - 1) / 3;
            end else begin
                t[k] = T_NEG_ONE;
                x = (x + 1) / 3;
            end
        end
        return t;
    endfunction

    // Advance one clock; inputs are driven and outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input trit_t [7:0] res, input trit_t cy, input logic z, input logic n,
                         input logic [3:0] rd, input logic we, input logic fwe);
        in_valid    = 1'b1;
        in_result   = res;
        in_carry    = cy;
        in_zero     = z;
        in_neg      = n;
        in_rd       = rd;
        in_we       = we;
        in_flags_we = fwe;
    endtask

    trit_t [7:0] bad;
    logic        saw_we;

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_result   = to_bt(0);
        in_carry    = T_ZERO;
        in_zero     = 1'b0;
        in_neg      = 1'b0;
        in_rd       = 4'd0;
        in_we       = 1'b0;
        in_flags_we = 1'b0;
        wb_ready    = 1'b1;
        err_clr     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_wb_valid", wb_valid, 0);
        check_eq("rst_flag_z", flag_z, 0);
        check_eq("rst_flag_n", flag_n, 0);
        check_eq("rst_flag_c", flag_c, T_ZERO);
        check_eq("rst_err", err_sticky, 0);
        check_eq("rst_wb_data", wb_data, 16'h0000);
        check_eq("rst_wb_rd", wb_rd, 0);

        // Single push of +1, one-cycle latency
        drive(to_bt(1), T_ZERO, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        check_eq("single_valid", wb_valid, 1);
        check_eq("single_rd", wb_rd, 3);
        check_eq("single_we", wb_we, 1);
        check_eq("single_data", wb_data, 16'h0001);
        tick();
        check_eq("single_drained", wb_valid, 0);
        check_eq("single_flag_z", flag_z, 0);
        check_eq("single_flag_n", flag_n, 0);
        check_eq("single_flag_c", flag_c, T_ZERO);

        // Flag-writing entry: zero=1, carry=+1; then a non-flag-writing neg=1
        drive(to_bt(0), T_POS_ONE, 1'b1, 1'b0, 4'd4, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        check_eq("flag_before_pop_z", flag_z, 0);
        tick();
        check_eq("flag_upd_z", flag_z, 1);
        check_eq("flag_upd_c", flag_c, T_POS_ONE);
        drive(to_bt(-5), T_NEG_ONE, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        check_eq("noflag_z", flag_z, 1);
        check_eq("noflag_n", flag_n, 0);
        check_eq("noflag_c", flag_c, T_POS_ONE);

        // Back-pressure: three offered, two accepted, head held stable
        wb_ready = 1'b0;
        drive(to_bt(5), T_ZERO, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0);
        tick();
        check_eq("bp1_in_ready", in_ready, 1);
        check_eq("bp1_rd", wb_rd, 1);
        drive(to_bt(-7), T_ZERO, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0);
        tick();
        check_eq("bp2_in_ready", in_ready, 0);
        check_eq("bp2_rd", wb_rd, 1);
        drive(to_bt(11), T_ZERO, 1'b0, 1'b0, 4'd9, 1'b1, 1'b0);
        tick();
        check_eq("bp3_in_ready", in_ready, 0);
        check_eq("bp3_valid", wb_valid, 1);
        check_eq("bp3_rd", wb_rd, 1);
        check_eq("bp3_data", wb_data, to_bt(5));
        in_valid = 1'b0;
        wb_ready = 1'b1;
        tick();
        check_eq("bp_pop1_valid", wb_valid, 1);
        check_eq("bp_pop1_rd", wb_rd, 2);
        check_eq("bp_pop1_data", wb_data, to_bt(-7));
        check_eq("bp_pop1_in_ready", in_ready, 1);
        tick();
        check_eq("bp_pop2_empty", wb_valid, 0);

        // Streaming ten results at full throughput
        for (int i = 0; i < 10; i++) begin
            drive(to_bt(i * 7 - 30), T_ZERO, 1'b0, 1'b0, 4'(i), 1'b1, 1'b0);
            tick();
            check_eq($sformatf("stream%0d_valid", i), wb_valid, 1);
            check_eq($sformatf("stream%0d_rd", i), wb_rd, i);
            check_eq($sformatf("stream%0d_data", i), wb_data, to_bt(i * 7 - 30));
            check_eq($sformatf("stream%0d_in_ready", i), in_ready, 1);
        end
        in_valid = 1'b0;
        tick();
        check_eq("stream_drained", wb_valid, 0);

        // Invalid result trit: write suppressed, flags held, error set
        bad = to_bt(4);
        bad[5] = T_INVALID;
        drive(bad, T_ZERO, 1'b0, 1'b1, 4'd6, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        check_eq("inv1_valid", wb_valid, 1);
        check_eq("inv1_we", wb_we, 0);
        check_eq("inv1_err_pre", err_sticky, 0);
        tick();
        check_eq("inv1_flag_z", flag_z, 1);
        check_eq("inv1_flag_n", flag_n, 0);
        check_eq("inv1_err", err_sticky, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("err_clr", err_sticky, 0);

        // Invalid carry; clear coincides with the pop, set wins
        drive(to_bt(2), T_INVALID, 1'b0, 1'b0, 4'd7, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        check_eq("inv2_we", wb_we, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("inv2_set_wins", err_sticky, 1);
        check_eq("inv2_flag_c", flag_c, T_POS_ONE);

`ifdef TERNARY_WB_FWD_EN
        // Forwarding mirrors the head
        wb_ready = 1'b0;
        drive(to_bt(13), T_ZERO, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0);
        tick();
        drive(to_bt(-2), T_ZERO, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        check_eq("fwd_valid", fwd_valid, 1);
        check_eq("fwd_rd", fwd_rd, 7);
        check_eq("fwd_data", fwd_data, to_bt(13));
        wb_ready = 1'b1;
        tick();
        check_eq("fwd_head_rd", wb_rd, 8);
        check_eq("fwd_valid_we0", fwd_valid, 0);
        tick();
`endif

        // Reset mid-operation with two buffered entries
        wb_ready = 1'b0;
        drive(to_bt(9), T_ZERO, 1'b0, 1'b0, 4'd10, 1'b1, 1'b1);
        tick();
        drive(to_bt(-9), T_ZERO, 1'b0, 1'b0, 4'd11, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        check_eq("mid_full", in_ready, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("mid_valid", wb_valid, 0);
        check_eq("mid_in_ready", in_ready, 1);
        check_eq("mid_flag_z", flag_z, 0);
        check_eq("mid_flag_c", flag_c, T_ZERO);
        check_eq("mid_err", err_sticky, 0);
        check_eq("mid_wb_rd", wb_rd, 0);
        check_eq("mid_wb_data", wb_data, 16'h0000);
        wb_ready = 1'b1;
        saw_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            saw_we = saw_we | (wb_valid & wb_we);
        end
        check_eq("mid_no_we_pulse", saw_we, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
